pipe_mem_stage: RTL and testbench

- M stage of the 5-stage MIPS pipeline; the reader side of the E→M pipeline register.
- Consumes the E-register outputs: pc, code, ALU result/memaddr, memwridata, rgwriaddr and rgwritime.
- Owns the word data memory, executes lw/sw, and drives the M_* forwarding sources back to E.
- Registers the M→W bundle for the W stage.

---
 rtl/mips_defs.sv | 57 +++++
 rtl/pipe_mem_stage_if.sv | 40 ++++
 rtl/dm_word_ram.sv | 49 ++++
 rtl/pipe_mem_stage.sv | 109 ++++++++++
 tb/tb_pipe_mem_stage.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared MIPS decode constants and instruction classifier.
// Used by the D, E, M and W pipeline stages.
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_JAL     = 6'h03;

    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_JR      = 6'h08;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] TNEW_NONE = 32'd0;

    typedef enum logic [3:0] {
        INS_NOP = 4'd0,
        INS_ADD = 4'd1,
        INS_SUB = 4'd2,
        INS_ORI = 4'd3,
        INS_LUI = 4'd4,
        INS_LW  = 4'd5,
        INS_SW  = 4'd6,
        INS_BEQ = 4'd7,
        INS_JAL = 4'd8,
        INS_JR  = 4'd9
    } instr_e;

    // Anything outside the supported subset collapses to INS_NOP.
    function automatic instr_e decode_instr(input logic [31:0] code);
        instr_e kind;
        kind = INS_NOP;
        case (code[31:26])
            OP_SPECIAL: begin
                case (code[5:0])
                    FN_ADD:  kind = INS_ADD;
                    FN_SUB:  kind = INS_SUB;
                    FN_JR:   kind = INS_JR;
                    default: kind = INS_NOP;
                endcase
            end
            OP_ORI:  kind = INS_ORI;
            OP_LUI:  kind = INS_LUI;
            OP_LW:   kind = INS_LW;
            OP_SW:   kind = INS_SW;
            OP_BEQ:  kind = INS_BEQ;
            OP_JAL:  kind = INS_JAL;
            default: kind = INS_NOP;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// E->M inputs, W-stage forwarding inputs, M forwarding sources and the M->W bundle.
// master drives the stage (E register / W stage side); slave is the M stage itself.
interface pipe_mem_stage_if;

    logic [31:0] pc;
    logic [31:0] code;
    logic [31:0] memaddr;
    logic [31:0] memwridata;
    logic [4:0]  rgwriaddr;
    logic [31:0] rgwritime;

    logic [4:0]  W_rgwriaddr;
    logic [31:0] W_rgwridata;
    logic [31:0] W_rgwritime;

    logic [4:0]  M_rgwriaddr;
    logic [31:0] M_rgwridata;
    logic [31:0] M_rgwritime;

    logic [31:0] npc;
    logic [31:0] ncode;
    logic [4:0]  nrgwriaddr;
    logic [31:0] nrgwridata;
    logic [31:0] nrgwritime;

    modport master (
        output pc, code, memaddr, memwridata, rgwriaddr, rgwritime,
        output W_rgwriaddr, W_rgwridata, W_rgwritime,
        input  M_rgwriaddr, M_rgwridata, M_rgwritime,
        input  npc, ncode, nrgwriaddr, nrgwridata, nrgwritime
    );

    modport slave (
        input  pc, code, memaddr, memwridata, rgwriaddr, rgwritime,
        input  W_rgwriaddr, W_rgwridata, W_rgwritime,
        output M_rgwriaddr, M_rgwridata, M_rgwritime,
        output npc, ncode, nrgwriaddr, nrgwridata, nrgwritime
    );

endinterface

// File: rtl/dm_word_ram.sv
// Word-addressed data memory: synchronous write, asynchronous read, full clear on reset.
// Addresses above the array are ignored on write and read back as zero.
module dm_word_ram #(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    logic [31:0]      mem_q [DM_WORDS];
    logic             in_range_s;
    logic [DM_AW-1:0] index_s;
    logic [1:0]       unused_byte_off_s;

    // Byte offset is dropped: every access is treated as word-aligned.
    always_comb begin
        in_range_s        = (addr_i[31:DM_AW+2] == '0);
        index_s           = addr_i[DM_AW+1:2];
        unused_byte_off_s = addr_i[1:0];
    end

    // Storage update: reset wipes every word and masks any concurrent store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (we_i && in_range_s) begin
            mem_q[index_s] <= wdata_i;
        end else begin
            mem_q[index_s] <= mem_q[index_s];
        end
    end

    // Asynchronous read path with out-of-range guard.
    always_comb begin
        if (in_range_s) begin
            rdata_o = mem_q[index_s];
        end else begin
            rdata_o = 32'd0;
        end
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MIPS M stage: executes lw/sw against the data memory, sources M-stage forwarding
// data back to E and registers the M->W bundle.
module pipe_mem_stage
    import mips_defs::*;
#(
    parameter int          DM_WORDS = 1024,
    parameter int          DM_AW    = 10,
    parameter logic [31:0] RESET_PC = mips_defs::RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    pipe_mem_stage_if.slave    bus
);

    instr_e      instr_s;
    logic [4:0]  rt_s;
    logic [31:0] m_data_s;
    logic [31:0] st_data_s;
    logic        st_en_s;
    logic [31:0] rd_data_s;

    logic [31:0] npc_d, npc_q;
    logic [31:0] ncode_d, ncode_q;
    logic [4:0]  nwa_d, nwa_q;
    logic [31:0] nwd_d, nwd_q;
    logic [31:0] nwt_d, nwt_q;

    dm_word_ram #(
        .DM_WORDS (DM_WORDS),
        .DM_AW    (DM_AW)
    ) u_dm (
        .clk     (clk),
        .reset   (reset),
        .we_i    (st_en_s),
        .addr_i  (bus.memaddr),
        .wdata_i (st_data_s),
        .rdata_o (rd_data_s)
    );

    // Decode plus forwarding-source data; lw exposes its address, never consumed (T_new=1).
    always_comb begin
        instr_s  = decode_instr(bus.code);
        rt_s     = bus.code[20:16];
        m_data_s = 32'd0;
        if (bus.rgwriaddr == 5'd0) begin
            m_data_s = 32'd0;
        end else begin
            case (instr_s)
                INS_JAL:                                  m_data_s = bus.pc + 32'd8;
                INS_ADD, INS_SUB, INS_ORI, INS_LUI, INS_LW: m_data_s = bus.memaddr;
                default:                                  m_data_s = 32'd0;
            endcase
        end
    end

    // Store data takes the W-stage result when W holds a ready value for rt.
    always_comb begin
        st_en_s = (instr_s == INS_SW);
        if ((bus.W_rgwritime == TNEW_NONE) && (bus.W_rgwriaddr == rt_s) && (rt_s != 5'd0)) begin
            st_data_s = bus.W_rgwridata;
        end else begin
            st_data_s = bus.memwridata;
        end
    end

    // Next-state for the M->W bundle; T_new counts down and sticks at zero.
    always_comb begin
        npc_d   = bus.pc;
        ncode_d = bus.code;
        nwa_d   = bus.rgwriaddr;
        if (bus.rgwritime == TNEW_NONE) begin
            nwt_d = TNEW_NONE;
        end else begin
            nwt_d = bus.rgwritime - 32'd1;
        end
        if (instr_s == INS_LW) begin
            nwd_d = rd_data_s;
        end else begin
            nwd_d = m_data_s;
        end
    end

    // M->W pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            npc_q   <= RESET_PC;
            ncode_q <= 32'd0;
            nwa_q   <= 5'd0;
            nwd_q   <= 32'd0;
            nwt_q   <= TNEW_NONE;
        end else begin
            npc_q   <= npc_d;
            ncode_q <= ncode_d;
            nwa_q   <= nwa_d;
            nwd_q   <= nwd_d;
            nwt_q   <= nwt_d;
        end
    end

    assign bus.M_rgwriaddr = bus.rgwriaddr;
    assign bus.M_rgwridata = m_data_s;
    assign bus.M_rgwritime = bus.rgwritime;
    assign bus.npc         = npc_q;
    assign bus.ncode       = ncode_q;
    assign bus.nrgwriaddr  = nwa_q;
    assign bus.nrgwridata  = nwd_q;
    assign bus.nrgwritime  = nwt_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed plus randomized bench for pipe_mem_stage, checked against a word-array
// reference model of the M stage's architectural behaviour.
module tb_pipe_mem_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_mem_stage_if bus ();

    pipe_mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    logic [31:0] ref_mem [1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [5:0] fn);
        return {op, 5'd0, rt, 10'd0, fn};
    endfunction

    // Value an instruction would write back, straight from the ISA rules.
    function automatic logic [31:0] wb_value(input logic [31:0] code, input logic [31:0] pc,
                                             input logic [31:0] addr, input logic [4:0] wa);
        logic [5:0] op;
        logic [5:0] fn;
        op = code[31:26];
        fn = code[5:0];
        if (wa == 5'd0) return 32'd0;
        if (op == 6'h03) return pc + 32'd8;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) return addr;
        if (op == 6'h0d || op == 6'h0f || op == 6'h23) return addr;
        return 32'd0;
    endfunction

    // One pipeline cycle: drive, check forwarding sources, clock, check W bundle, update model.
    task automatic cycle(input logic rst, input logic [31:0] pc, input logic [31:0] code,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wa,
                         input logic [31:0] wt, input logic [4:0] wwa, input logic [31:0] wwd,
                         input logic [31:0] wwt);
        logic [31:0] e_m, e_rd, e_npc, e_code, e_wd, e_wt, st;
        logic [4:0]  e_wa, rt;
        logic        in_rng, is_lw, is_sw;
        reset          = rst;
        bus.pc         = pc;
        bus.code       = code;
        bus.memaddr    = addr;
        bus.memwridata = wd;
        bus.rgwriaddr  = wa;
        bus.rgwritime  = wt;
        bus.W_rgwriaddr = wwa;
        bus.W_rgwridata = wwd;
        bus.W_rgwritime = wwt;
        rt     = code[20:16];
        is_lw  = (code[31:26] == 6'h23);
        is_sw  = (code[31:26] == 6'h2b);
        in_rng = (addr < 32'd4096);
        e_m    = wb_value(code, pc, addr, wa);
        e_rd   = in_rng ? ref_mem[addr[11:2]] : 32'd0;
        #2;
        chk("M_rgwriaddr", {27'd0, bus.M_rgwriaddr}, {27'd0, wa});
        chk("M_rgwridata", bus.M_rgwridata, e_m);
        chk("M_rgwritime", bus.M_rgwritime, wt);
        if (rst) begin
            e_npc = 32'h0000_3000; e_code = 32'd0; e_wa = 5'd0; e_wd = 32'd0; e_wt = 32'd0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        end else begin
            e_npc = pc; e_code = code; e_wa = wa;
            e_wd  = is_lw ? e_rd : e_m;
            e_wt  = (wt > 32'd0) ? wt - 32'd1 : 32'd0;
            st    = (wwt == 32'd0 && wwa == rt && rt != 5'd0) ? wwd : wd;
            if (is_sw && in_rng) ref_mem[addr[11:2]] = st;
        end
        @(posedge clk);
        #1;
        chk("npc", bus.npc, e_npc);
        chk("ncode", bus.ncode, e_code);
        chk("nrgwriaddr", {27'd0, bus.nrgwriaddr}, {27'd0, e_wa});
        chk("nrgwridata", bus.nrgwridata, e_wd);
        chk("nrgwritime", bus.nrgwritime, e_wt);
    endtask

    initial begin
        logic [31:0] ADD, JAL, NOP, code, addr;
        logic [5:0]  ops [10];
        ADD = mk(6'h00, 5'd0, 6'h20);
        JAL = mk(6'h03, 5'd0, 6'h00);
        NOP = 32'd0;
        ops = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h03, 6'h3f};

        // 1. reset, then lw from 0
        cycle(1'b1, 32'h0, NOP, 32'h0, 32'h0, 5'd0, 32'd0, 5'd0, 32'h0, 32'd1);
        cycle(1'b0, 32'h3000, mk(6'h23, 5'd2, 6'h0), 32'h0, 32'h0, 5'd2, 32'd1, 5'd0, 32'h0, 32'd1);
        chk("tp1_lw0", bus.nrgwridata, 32'd0);

        // 2. sw then lw
        cycle(1'b0, 32'h3004, mk(6'h2b, 5'd9, 6'h0), 32'h10, 32'hDEAD_BEEF, 5'd0, 32'd0, 5'd0, 32'h0, 32'd1);
        cycle(1'b0, 32'h3008, mk(6'h23, 5'd8, 6'h0), 32'h10, 32'h0, 5'd8, 32'd1, 5'd0, 32'h0, 32'd1);
        chk("tp2_lw", bus.nrgwridata, 32'hDEAD_BEEF);
        chk("tp2_wt", bus.nrgwritime, 32'd0);

        // 3. sw with W forwarding, then without
        cycle(1'b0, 32'h300c, mk(6'h2b, 5'd5, 6'h0), 32'h8, 32'h1, 5'd0, 32'd0, 5'd5, 32'h1234, 32'd0);
        cycle(1'b0, 32'h3010, mk(6'h23, 5'd6, 6'h0), 32'h8, 32'h0, 5'd6, 32'd1, 5'd0, 32'h0, 32'd1);
        chk("tp3_fwd", bus.nrgwridata, 32'h1234);
        cycle(1'b0, 32'h3014, mk(6'h2b, 5'd5, 6'h0), 32'h8, 32'h1, 5'd0, 32'd0, 5'd5, 32'h1234, 32'd1);
        cycle(1'b0, 32'h3018, mk(6'h23, 5'd6, 6'h0), 32'h8, 32'h0, 5'd6, 32'd1, 5'd0, 32'h0, 32'd1);
        chk("tp3_nofwd", bus.nrgwridata, 32'h1);

        // 4. M forwarding sources
        cycle(1'b0, 32'h301c, ADD, 32'h7, 32'h0, 5'd3, 32'd0, 5'd0, 32'h0, 32'd1);
        chk("tp4_add", bus.nrgwridata, 32'h7);
        cycle(1'b0, 32'h3008, JAL, 32'h0, 32'h0, 5'd31, 32'd0, 5'd0, 32'h0, 32'd1);
        chk("tp4_jal", bus.nrgwridata, 32'h3010);
        cycle(1'b0, 32'h3020, ADD, 32'h55, 32'h0, 5'd0, 32'd0, 5'd0, 32'h0, 32'd1);

        // 5. out of range
        cycle(1'b0, 32'h3024, mk(6'h2b, 5'd4, 6'h0), 32'h1000, 32'hFFFF_0001, 5'd0, 32'd0, 5'd0, 32'h0, 32'd1);
        cycle(1'b0, 32'h3028, mk(6'h23, 5'd4, 6'h0), 32'h0, 32'h0, 5'd4, 32'd1, 5'd0, 32'h0, 32'd1);
        chk("tp5_lw0", bus.nrgwridata, 32'd0);
        cycle(1'b0, 32'h302c, mk(6'h23, 5'd4, 6'h0), 32'h1000, 32'h0, 5'd4, 32'd1, 5'd0, 32'h0, 32'd1);
        chk("tp5_oor", bus.nrgwridata, 32'd0);

        // 6. reset mid-stream with a pending sw
        cycle(1'b0, 32'h3030, mk(6'h2b, 5'd4, 6'h0), 32'h4, 32'hA5A5_A5A5, 5'd0, 32'd0, 5'd0, 32'h0, 32'd1);
        cycle(1'b1, 32'h3034, mk(6'h2b, 5'd4, 6'h0), 32'h4, 32'h5A5A_5A5A, 5'd0, 32'd0, 5'd0, 32'h0, 32'd1);
        cycle(1'b0, 32'h3038, mk(6'h23, 5'd4, 6'h0), 32'h4, 32'h0, 5'd4, 32'd0, 5'd0, 32'h0, 32'd1);
        chk("tp6_lw", bus.nrgwridata, 32'd0);
        chk("tp6_sat", bus.nrgwritime, 32'd0);

        // Randomized traffic over a small address window with occasional out-of-range hits.
        for (int n = 0; n < 400; n++) begin
            int k;
            k = $urandom_range(0, 9);
            code = mk(ops[k], 5'($urandom_range(0, 7)), 6'd0);
            if (k == 0) code[5:0] = 6'h20;
            if (k == 1) code[5:0] = 6'h22;
            if (k == 2) code[5:0] = 6'h08;
            if ($urandom_range(0, 9) == 0) code = $urandom;
            addr = {24'd0, 6'($urandom_range(0, 31)), 2'($urandom)};
            if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h0000_1000;
            cycle(($urandom_range(0, 63) == 0), $urandom, code, addr, $urandom,
                  5'($urandom_range(0, 31)), 32'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
